// File: rtl/per_addr_dec_pkg.sv
// Shared window constants, target encoding and window-hit helper for the
// per-master request-side address decoder.
package per_addr_dec_pkg;

    localparam logic [11:0] WIN_BASE    = 12'h100;
    localparam logic [11:0] WIN_HIT_OFS = 12'd2;
    localparam int          TGT_IDX_W   = 8;

    typedef enum logic {
        TGT_SLAVE = 1'b0,
        TGT_ERR   = 1'b1
    } tgt_kind_e;

    typedef struct packed {
        tgt_kind_e              kind;
        logic [TGT_IDX_W-1:0]   idx;
    } tgt_t;

    // A window is hit when the top address nibbles equal the window base plus the hit offset.
    function automatic logic win_hit(input logic [11:0] addr_hi, input logic [11:0] base);
        return addr_hi == (base + WIN_HIT_OFS);
    endfunction

endpackage

// File: rtl/per_ot_counter.sv
// Outstanding-transaction tracker: counts granted-but-unanswered slave
// requests and remembers which slave they went to.
module per_ot_counter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int N_SLAVE         = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       hs_i,
    input  logic [$clog2(N_SLAVE)-1:0] tgt_i,
    input  logic                       rsp_i,
    output logic [$clog2(N_SLAVE)-1:0] last_tgt_o,
    output logic                       full_o,
    output logic                       zero_o
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int SW = $clog2(N_SLAVE);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] last_tgt_q, last_tgt_d;

    // A response with nothing outstanding is dropped so the count never wraps.
    always_comb begin
        cnt_d      = cnt_q;
        last_tgt_d = last_tgt_q;
        if (hs_i) begin
            cnt_d      = cnt_d + CW'(1);
            last_tgt_d = tgt_i;
        end
        if (rsp_i && (cnt_q != '0)) begin
            cnt_d = cnt_d - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            last_tgt_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            last_tgt_q <= last_tgt_d;
        end
    end

    assign last_tgt_o = last_tgt_q;
    assign full_o     = (cnt_q == MAX_CNT);
    assign zero_o     = (cnt_q == '0);

    rsp_when_empty: assert property (@(posedge clk) disable iff (!rst_n) !(rsp_i && zero_o));

endmodule

// File: rtl/per_addr_dec_req_ot.sv
// Request-side address decoder for one master: routes to a peripheral port or
// the internal error responder, holding back requests that could reorder responses.
module per_addr_dec_req_ot
    import per_addr_dec_pkg::*;
#(
    parameter int          ID_WIDTH           = 17,
    parameter int          ID                 = 1,
    parameter int          N_SLAVE            = 16,
    parameter int          LOG_CLUSTER        = 5,
    parameter int          ADDR_WIDTH         = 32,
    parameter int          PE_ROUTING_LSB     = 16,
    parameter int          PE_ROUTING_MSB     = 19,
    parameter int          CLUSTER_ALIAS      = 0,
    parameter logic [11:0] CLUSTER_ALIAS_BASE = 12'h000,
    parameter int          MAX_OUTSTANDING    = 4,
    parameter int          DEFAULT_SLAVE      = N_SLAVE - 1,
    parameter int          ERR_RESP           = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [LOG_CLUSTER-1:0] CLUSTER_ID,
    input  logic                   data_req_i,
    input  logic [ADDR_WIDTH-1:0]  data_add_i,
    output logic                   data_gnt_o,
    output logic [N_SLAVE-1:0]     data_req_o,
    input  logic [N_SLAVE-1:0]     data_gnt_i,
    output logic [ID_WIDTH-1:0]    data_ID_o,
    input  logic                   rsp_valid_i,
    output logic                   err_valid_o
);

    localparam int SW = $clog2(N_SLAVE);
    localparam int RW = PE_ROUTING_MSB - PE_ROUTING_LSB + 1;

    tgt_t          tgt;
    logic [11:0]   addr_hi;
    logic [RW-1:0] route_idx;
    logic          any_hit;
    logic [SW-1:0] slave_idx;
    logic [SW-1:0] last_tgt;
    logic          ot_full, ot_zero;
    logic          slave_blk, err_blk;
    logic          slave_hs, err_grant;
    logic          err_pend_q, err_pend_d;
    logic          unused_bits;

    always_comb begin
        tgt       = '{kind: TGT_SLAVE, idx: '0};
        addr_hi   = data_add_i[31:20];
        route_idx = data_add_i[PE_ROUTING_MSB:PE_ROUTING_LSB];
        any_hit   = win_hit(addr_hi, WIN_BASE + (12'(CLUSTER_ID) << 2))
                  || ((CLUSTER_ALIAS != 0) && win_hit(addr_hi, CLUSTER_ALIAS_BASE));
        if (any_hit && (32'(route_idx) < 32'(N_SLAVE))) begin
            tgt.idx = TGT_IDX_W'(route_idx);
        end else if (ERR_RESP != 0) begin
            tgt.kind = TGT_ERR;
        end else begin
            tgt.idx = TGT_IDX_W'(DEFAULT_SLAVE);
        end
    end

    assign slave_idx = tgt.idx[SW-1:0];

    // Only one slave may have traffic in flight, and the error responder needs everything drained.
    always_comb begin
        slave_blk  = err_pend_q || ot_full || (!ot_zero && (slave_idx != last_tgt));
        err_blk    = !ot_zero || err_pend_q;
        data_req_o = '0;
        data_gnt_o = 1'b0;
        slave_hs   = 1'b0;
        err_grant  = 1'b0;
        if (tgt.kind == TGT_SLAVE) begin
            if (!slave_blk) begin
                data_req_o[slave_idx] = data_req_i;
                data_gnt_o            = data_gnt_i[slave_idx];
                slave_hs              = data_req_i && data_gnt_i[slave_idx];
            end
        end else if (!err_blk) begin
            data_gnt_o = data_req_i;
            err_grant  = data_req_i;
        end
        err_pend_d = err_grant;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pend_q <= 1'b0;
        end else begin
            err_pend_q <= err_pend_d;
        end
    end

    per_ot_counter #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .N_SLAVE         (N_SLAVE)
    ) u_ot_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .hs_i       (slave_hs),
        .tgt_i      (slave_idx),
        .rsp_i      (rsp_valid_i),
        .last_tgt_o (last_tgt),
        .full_o     (ot_full),
        .zero_o     (ot_zero)
    );

    assign err_valid_o = err_pend_q;
    assign data_ID_o   = ID_WIDTH'(ID);
    assign unused_bits = ^{data_add_i, tgt.idx};

endmodule

// File: tb/tb_per_addr_dec_req_ot.sv
// Bench for per_addr_dec_req_ot: instance A (alias on, default slave) and
// instance B (error responder) share request inputs but have separate responses.
module tb_per_addr_dec_req_ot;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  cid;
    logic        req;
    logic [31:0] addr;
    logic [15:0] gnt_i;
    logic        rsp_a, rsp_b;
    logic        gnt_a, gnt_b, err_a, err_b;
    logic [15:0] req_o_a, req_o_b;
    logic [16:0] id_a, id_b;

    always #5 clk = ~clk;

    per_addr_dec_req_ot #(
        .CLUSTER_ALIAS(1), .CLUSTER_ALIAS_BASE(12'h1B0), .ERR_RESP(0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .CLUSTER_ID(cid), .data_req_i(req), .data_add_i(addr),
        .data_gnt_o(gnt_a), .data_req_o(req_o_a), .data_gnt_i(gnt_i), .data_ID_o(id_a),
        .rsp_valid_i(rsp_a), .err_valid_o(err_a)
    );

    per_addr_dec_req_ot #(
        .CLUSTER_ALIAS(0), .ERR_RESP(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .CLUSTER_ID(cid), .data_req_i(req), .data_add_i(addr),
        .data_gnt_o(gnt_b), .data_req_o(req_o_b), .data_gnt_i(gnt_i), .data_ID_o(id_b),
        .rsp_valid_i(rsp_b), .err_valid_o(err_b)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: outstanding count, slave they went to, pending error response.
    bit m_alias [2] = '{1'b1, 1'b0};
    bit m_errrsp[2] = '{1'b0, 1'b1};
    int m_cnt   [2];
    int m_last  [2];
    bit m_ep    [2];

    function automatic int m_target(input int m, input logic [31:0] a, input int c);
        int hi;
        bit hit;
        hi  = int'(a[31:20]);
        hit = (hi == 'h100 + c * 4 + 2) || (m_alias[m] && hi == 'h1B0 + 2);
        if (hit && int'(a[19:16]) < 16) return int'(a[19:16]);
        return m_errrsp[m] ? -1 : 15;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        req = 1'b0; addr = '0; gnt_i = '0; rsp_a = 1'b0; rsp_b = 1'b0; cid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int m = 0; m < 2; m++) begin
            m_cnt[m] = 0; m_last[m] = 0; m_ep[m] = 1'b0;
        end
    endtask

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic [15:0] gnt;
        logic        rsp_a;
        logic        rsp_b;
        logic [15:0] exp_req_a;
        logic        exp_gnt_a;
        logic [15:0] exp_req_b;
        logic        exp_gnt_b;
        logic        exp_err_b;
    } vec_t;

    vec_t tbl[16];

    initial begin
        // Same-target burst, target switch, simultaneous handshake+response,
        // unmapped default/error routing, back-to-back errors, alias.
        tbl[0]  = '{1'b1, 32'h1023_0000, 16'h0008, 1'b0, 1'b0, 16'h0008, 1'b1, 16'h0008, 1'b1, 1'b0};
        tbl[1]  = tbl[0];
        tbl[2]  = tbl[0];
        tbl[3]  = tbl[0];
        tbl[4]  = '{1'b1, 32'h1023_0000, 16'h0008, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 32'h1025_0000, 16'h0020, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[6]  = tbl[5];
        tbl[7]  = '{1'b1, 32'h1023_0000, 16'h0008, 1'b1, 1'b1, 16'h0008, 1'b1, 16'h0008, 1'b1, 1'b0};
        tbl[8]  = tbl[5];
        tbl[9]  = tbl[5];
        tbl[10] = '{1'b1, 32'h1025_0000, 16'h0020, 1'b0, 1'b0, 16'h0020, 1'b1, 16'h0020, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 32'h1025_0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 32'h2000_0000, 16'h8000, 1'b0, 1'b0, 16'h8000, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 32'h2000_0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1};
        tbl[14] = '{1'b1, 32'h2000_0000, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[15] = '{1'b1, 32'h1B24_0000, 16'h0010, 1'b0, 1'b0, 16'h0010, 1'b1, 16'h0000, 1'b0, 1'b1};

        do_reset();
        #1;
        chk("rst_err_a", 32'(err_a), 0);
        chk("rst_err_b", 32'(err_b), 0);
        chk("rst_req_a", 32'(req_o_a), 0);
        chk("rst_gnt_a", 32'(gnt_a), 0);
        chk("id_a", 32'(id_a), 1);
        chk("id_b", 32'(id_b), 1);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            req = tbl[i].req; addr = tbl[i].addr; gnt_i = tbl[i].gnt;
            rsp_a = tbl[i].rsp_a; rsp_b = tbl[i].rsp_b; cid = '0;
            #1;
            chk($sformatf("tbl%0d_req_a", i), 32'(req_o_a), 32'(tbl[i].exp_req_a));
            chk($sformatf("tbl%0d_gnt_a", i), 32'(gnt_a),   32'(tbl[i].exp_gnt_a));
            chk($sformatf("tbl%0d_err_a", i), 32'(err_a),   0);
            chk($sformatf("tbl%0d_req_b", i), 32'(req_o_b), 32'(tbl[i].exp_req_b));
            chk($sformatf("tbl%0d_gnt_b", i), 32'(gnt_b),   32'(tbl[i].exp_gnt_b));
            chk($sformatf("tbl%0d_err_b", i), 32'(err_b),   32'(tbl[i].exp_err_b));
        end

        // Reset mid-operation: A holds 3 outstanding to slave 15, B has an error pending.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req = 1'b1; addr = 32'h2000_0000; gnt_i = 16'h8000;
        end
        @(posedge clk);
        #2;
        addr = 32'h1025_0000; gnt_i = 16'h0020;
        #1;
        chk("pre_rst_err_b", 32'(err_b), 1);
        chk("pre_rst_req_a", 32'(req_o_a), 0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_err_b", 32'(err_b), 0);
        chk("async_rst_req_a", 32'(req_o_a), 32'h0020);
        chk("async_rst_gnt_a", 32'(gnt_a), 1);
        chk("async_rst_req_b", 32'(req_o_b), 32'h0020);
        chk("async_rst_gnt_b", 32'(gnt_b), 1);
        do_reset();

        // Randomized traffic against the reference model.
        for (int i = 0; i < 1500; i++) begin
            int sel, sl, hi;
            @(negedge clk);
            cid = 5'($urandom_range(0, 31));
            req = ($urandom_range(0, 3) != 0);
            sel = $urandom_range(0, 3);
            sl  = (sel == 0) ? 3 : (sel == 1) ? 5 : (sel == 2) ? 15 : $urandom_range(0, 15);
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: hi = 'h100 + int'(cid) * 4 + 2;
                6, 7:             hi = 'h1B2;
                8:                hi = 'h100 + int'(cid) * 4 + 3;
                default:          hi = $urandom_range(0, 4095);
            endcase
            addr  = {12'(hi), 4'(sl), 16'($urandom)};
            gnt_i = 16'($urandom);
            rsp_a = (m_cnt[0] > 0) && ($urandom_range(0, 2) == 0);
            rsp_b = (m_cnt[1] > 0) && ($urandom_range(0, 2) == 0);
            #1;
            for (int m = 0; m < 2; m++) begin
                int t;
                bit blk, hs, eg, rsp;
                logic [15:0] e_req;
                logic        e_gnt;
                t     = m_target(m, addr, int'(cid));
                e_req = '0;
                e_gnt = 1'b0;
                hs    = 1'b0;
                eg    = 1'b0;
                if (t >= 0) begin
                    blk = m_ep[m] || (m_cnt[m] == 4) || (m_cnt[m] != 0 && t != m_last[m]);
                    if (!blk) begin
                        e_req[t] = req;
                        e_gnt    = gnt_i[t];
                        hs       = req && gnt_i[t];
                    end
                end else begin
                    blk = (m_cnt[m] != 0) || m_ep[m];
                    if (!blk) begin
                        e_gnt = req;
                        eg    = req;
                    end
                end
                chk($sformatf("rnd%0d_req[%0d]", i, m), 32'((m == 0) ? req_o_a : req_o_b), 32'(e_req));
                chk($sformatf("rnd%0d_gnt[%0d]", i, m), 32'((m == 0) ? gnt_a : gnt_b), 32'(e_gnt));
                chk($sformatf("rnd%0d_err[%0d]", i, m), 32'((m == 0) ? err_a : err_b), 32'(m_ep[m]));
                rsp = (m == 0) ? rsp_a : rsp_b;
                m_cnt[m] = m_cnt[m] + (hs ? 1 : 0) - ((rsp && m_cnt[m] > 0) ? 1 : 0);
                if (hs) m_last[m] = t;
                m_ep[m] = eg;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
